// File: rtl/axi4_lite_master_pkg.sv
// Shared definitions for the CPU-side AXI4-Lite master: default bus widths,
// AXI response codes and the controller state encoding.
package axi4_lite_master_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_MASK_W = AXI_DATA_W / 8;
  localparam int AXI_RESP_W = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RD_ADDR = ST_RD_ADDR,
    S_RD_DATA = ST_RD_DATA,
    S_WR_REQ  = ST_WR_REQ,
    S_WR_RESP = ST_WR_RESP,
    S_RESP    = ST_RESP
  } state_e;

  // EXOKAY counts as an error: the CPU never issues exclusive accesses.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      RESP_OKAY:                              err = 1'b0;
      RESP_EXOKAY, RESP_SLVERR, RESP_DECERR:  err = 1'b1;
      default:                                err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axi4_lite_m_timeout.sv
// Watchdog for the AXI4-Lite master: counts cycles spent waiting in one
// channel state and flags expiry on the last allowed cycle.
module axi4_lite_m_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic iClock,
  input  logic iReset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A handshake landing on this same cycle still wins in the FSM.
  assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/axi4_lite_master.sv
// CPU-side AXI4-Lite master: one outstanding load/store, registered channel
// outputs. Optional watchdog enabled with `define AXI4_LITE_M_TIMEOUT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | ready for a request from IFU/LSU
// RD_ADDR  | ar_valid up, waiting for ar_ready
// RD_DATA  | r_ready up, waiting for r_valid
// WR_REQ   | aw/w valids up, each drops after its own handshake
// WR_RESP  | b_ready up, waiting for b_valid
// RESP     | response presented until the consumer takes it
module axi4_lite_master
  import axi4_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = AXI_ADDR_W,
  parameter int DATA_WIDTH     = AXI_DATA_W,
  parameter int MASK_WIDTH     = AXI_MASK_W,
  parameter int RESP_WIDTH     = AXI_RESP_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic                  iReqWr,
  input  logic [ADDR_WIDTH-1:0] iReqAddr,
  input  logic [DATA_WIDTH-1:0] iReqData,
  input  logic [MASK_WIDTH-1:0] iReqMask,
  output logic                  oRespValid,
  input  logic                  iRespReady,
  output logic [DATA_WIDTH-1:0] oRespData,
  output logic                  oRespErr,
  output logic                  pAXI4_ar_valid,
  output logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr,
  input  logic                  pAXI4_ar_ready,
  output logic                  pAXI4_r_ready,
  input  logic                  pAXI4_r_valid,
  input  logic [DATA_WIDTH-1:0] pAXI4_r_bits_data,
  input  logic [RESP_WIDTH-1:0] pAXI4_r_bits_resp,
  output logic                  pAXI4_aw_valid,
  output logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr,
  input  logic                  pAXI4_aw_ready,
  output logic                  pAXI4_w_valid,
  output logic [DATA_WIDTH-1:0] pAXI4_w_bits_data,
  output logic [MASK_WIDTH-1:0] pAXI4_w_bits_strb,
  input  logic                  pAXI4_w_ready,
  output logic                  pAXI4_b_ready,
  input  logic                  pAXI4_b_valid,
  input  logic [RESP_WIDTH-1:0] pAXI4_b_bits_resp
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("axi4_lite_master: TIMEOUT_CYCLES must be in 1..65536");
  end

  state_e state_d, state_q;
  logic ar_valid_d, ar_valid_q;
  logic r_ready_d, r_ready_q;
  logic aw_valid_d, aw_valid_q;
  logic w_valid_d, w_valid_q;
  logic b_ready_d, b_ready_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic [MASK_WIDTH-1:0] strb_d, strb_q;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic err_d, err_q;
  logic aw_pend, w_pend;
  logic abort;
  logic timeout_expired;

  always_comb begin
    state_d    = state_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    aw_pend    = aw_valid_q & ~pAXI4_aw_ready;
    w_pend     = w_valid_q & ~pAXI4_w_ready;
    abort      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iReqValid) begin
          addr_d  = iReqAddr;
          wdata_d = iReqData;
          strb_d  = iReqMask;
          if (iReqWr) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = S_WR_REQ;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (pAXI4_ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RD_DATA;
        end else if (timeout_expired) begin
          abort = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (pAXI4_r_valid) begin
          r_ready_d = 1'b0;
          rdata_d   = pAXI4_r_bits_data;
          err_d     = resp_is_err(pAXI4_r_bits_resp);
          state_d   = S_RESP;
        end else if (timeout_expired) begin
          abort = 1'b1;
        end
      end
      S_WR_REQ: begin
        aw_valid_d = aw_pend;
        w_valid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          b_ready_d = 1'b1;
          state_d   = S_WR_RESP;
        end else if (timeout_expired) begin
          abort = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (pAXI4_b_valid) begin
          b_ready_d = 1'b0;
          rdata_d   = '0;
          err_d     = resp_is_err(pAXI4_b_bits_resp);
          state_d   = S_RESP;
        end else if (timeout_expired) begin
          abort = 1'b1;
        end
      end
      S_RESP: begin
        if (iRespReady) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Watchdog expiry: release every channel and report an error response.
    if (abort) begin
      ar_valid_d = 1'b0;
      r_ready_d  = 1'b0;
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      b_ready_d  = 1'b0;
      rdata_d    = '0;
      err_d      = 1'b1;
      state_d    = S_RESP;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q    <= S_IDLE;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

`ifdef AXI4_LITE_M_TIMEOUT_EN
  logic waiting;

  assign waiting = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                   (state_q == S_WR_REQ)  || (state_q == S_WR_RESP);

  axi4_lite_m_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .iClock   (iClock),
    .iReset   (iReset),
    .clear    (state_d != state_q),
    .count_en (waiting),
    .expired  (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  assign oReqReady          = (state_q == S_IDLE);
  assign oRespValid         = (state_q == S_RESP);
  assign oRespData          = rdata_q;
  assign oRespErr           = err_q;
  assign pAXI4_ar_valid     = ar_valid_q;
  assign pAXI4_ar_bits_addr = addr_q;
  assign pAXI4_r_ready      = r_ready_q;
  assign pAXI4_aw_valid     = aw_valid_q;
  assign pAXI4_aw_bits_addr = addr_q;
  assign pAXI4_w_valid      = w_valid_q;
  assign pAXI4_w_bits_data  = wdata_q;
  assign pAXI4_w_bits_strb  = strb_q;
  assign pAXI4_b_ready      = b_ready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: directed transactions against a
// configurable slave, with a transaction-level response/busy model.
module tb_axi4_lite_master;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int RW = 2;
  localparam int TO = 8;

  logic          iClock = 1'b0;
  logic          iReset = 1'b0;
  logic          iReqValid = 1'b0;
  logic          oReqReady;
  logic          iReqWr = 1'b0;
  logic [AW-1:0] iReqAddr = '0;
  logic [DW-1:0] iReqData = '0;
  logic [MW-1:0] iReqMask = '0;
  logic          oRespValid;
  logic          iRespReady = 1'b1;
  logic [DW-1:0] oRespData;
  logic          oRespErr;
  logic          ar_valid, ar_ready = 1'b0;
  logic [AW-1:0] ar_addr;
  logic          r_ready, r_valid = 1'b0;
  logic [DW-1:0] r_data = '0;
  logic [RW-1:0] r_resp = '0;
  logic          aw_valid, aw_ready = 1'b0;
  logic [AW-1:0] aw_addr;
  logic          w_valid, w_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic [MW-1:0] w_strb;
  logic          b_ready, b_valid = 1'b0;
  logic [RW-1:0] b_resp = '0;

  axi4_lite_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .RESP_WIDTH(RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .iClock(iClock), .iReset(iReset),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWr(iReqWr),
    .iReqAddr(iReqAddr), .iReqData(iReqData), .iReqMask(iReqMask),
    .oRespValid(oRespValid), .iRespReady(iRespReady),
    .oRespData(oRespData), .oRespErr(oRespErr),
    .pAXI4_ar_valid(ar_valid), .pAXI4_ar_bits_addr(ar_addr), .pAXI4_ar_ready(ar_ready),
    .pAXI4_r_ready(r_ready), .pAXI4_r_valid(r_valid),
    .pAXI4_r_bits_data(r_data), .pAXI4_r_bits_resp(r_resp),
    .pAXI4_aw_valid(aw_valid), .pAXI4_aw_bits_addr(aw_addr), .pAXI4_aw_ready(aw_ready),
    .pAXI4_w_valid(w_valid), .pAXI4_w_bits_data(w_data),
    .pAXI4_w_bits_strb(w_strb), .pAXI4_w_ready(w_ready),
    .pAXI4_b_ready(b_ready), .pAXI4_b_valid(b_valid), .pAXI4_b_bits_resp(b_resp)
  );

  always #5 iClock = ~iClock;

  int cyc = 0;
  always @(posedge iClock) cyc++;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // Slave: each ready/valid rises after a configurable number of wait cycles.
  int          cfg_ar_lat = 0, cfg_r_lat = 0, cfg_aw_lat = 0, cfg_w_lat = 0, cfg_b_lat = 0;
  logic        cfg_ar_hang = 1'b0;
  logic [63:0] cfg_rdata = '0;
  logic [1:0]  cfg_resp = '0;
  int          ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;

  always @(posedge iClock) begin
    #1;
    ar_ready = ar_valid && !cfg_ar_hang && (ar_n >= cfg_ar_lat);
    ar_n     = ar_valid ? ar_n + 1 : 0;
    r_valid  = r_ready && (r_n >= cfg_r_lat);
    r_n      = r_ready ? r_n + 1 : 0;
    r_data   = r_valid ? cfg_rdata : 64'hBADB_ADBA_DBAD_BADB;
    r_resp   = cfg_resp;
    aw_ready = aw_valid && (aw_n >= cfg_aw_lat);
    aw_n     = aw_valid ? aw_n + 1 : 0;
    w_ready  = w_valid && (w_n >= cfg_w_lat);
    w_n      = w_valid ? w_n + 1 : 0;
    b_valid  = b_ready && (b_n >= cfg_b_lat);
    b_n      = b_ready ? b_n + 1 : 0;
    b_resp   = cfg_resp;
  end

  // Transaction-level model: busy from accept until response handshake.
  logic        busy = 1'b0;
  logic        chk_en = 1'b0;
  logic [64:0] exp_q[$];
  logic        exp_wr = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [63:0] exp_wdata = '0;
  logic [7:0]  exp_strb = '0;
  int          resp_hs_cyc = 0;
  int          resp_cnt = 0;
  int          acc_cyc = 0;
  int          resp_lat = 0;

  always @(negedge iClock) begin
    if (chk_en) begin
      if (!iReset) begin
        exp_q.delete();
        busy = 1'b0;
      end else begin
        chk("req_ready", {63'h0, oReqReady}, {63'h0, !busy});
        if (!busy || exp_wr) begin
          chk("ar_valid_off", {63'h0, ar_valid}, 64'h0);
          chk("r_ready_off", {63'h0, r_ready}, 64'h0);
        end
        if (!busy || !exp_wr) begin
          chk("aw_valid_off", {63'h0, aw_valid}, 64'h0);
          chk("w_valid_off", {63'h0, w_valid}, 64'h0);
          chk("b_ready_off", {63'h0, b_ready}, 64'h0);
        end
        if (!busy) chk("resp_valid_idle", {63'h0, oRespValid}, 64'h0);
        if (ar_valid) chk("ar_addr", {32'h0, ar_addr}, {32'h0, exp_addr});
        if (aw_valid) chk("aw_addr", {32'h0, aw_addr}, {32'h0, exp_addr});
        if (w_valid) begin
          chk("w_data", w_data, exp_wdata);
          chk("w_strb", {56'h0, w_strb}, {56'h0, exp_strb});
        end
        if (b_ready) chk("b_ready_early", {63'h0, aw_valid | w_valid}, 64'h0);
        if (r_ready) chk("r_ready_with_ar", {63'h0, ar_valid}, 64'h0);
        if (oRespValid) begin
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", {63'h0, oRespValid}, 64'h0);
          end else begin
            chk("resp_data", oRespData, exp_q[0][63:0]);
            chk("resp_err", {63'h0, oRespErr}, {63'h0, exp_q[0][64]});
            if (iRespReady) void'(exp_q.pop_front());
          end
        end
        if (iReqValid && oReqReady) busy = 1'b1;
        if (oRespValid && iRespReady) begin
          busy = 1'b0;
          resp_hs_cyc = cyc;
          resp_cnt++;
        end
      end
    end
  end

  // Called at #1 after a posedge; returns at #1 after the accept edge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] m);
    int n;
    n = 0;
    iReqValid = 1'b1; iReqWr = wr; iReqAddr = a; iReqData = d; iReqMask = m;
    while (!oReqReady && n < 200) begin
      @(posedge iClock); #1; n++;
    end
    if (!oReqReady) begin
      chk("req_accept_timeout", {63'h0, oReqReady}, 64'h1);
      iReqValid = 1'b0;
    end else begin
      acc_cyc = cyc;
      exp_wr = wr; exp_addr = a; exp_wdata = d; exp_strb = m;
      if (cfg_ar_hang)   exp_q.push_back({1'b1, 64'h0});
      else if (wr)       exp_q.push_back({cfg_resp != 2'b00, 64'h0});
      else               exp_q.push_back({cfg_resp != 2'b00, cfg_rdata});
      @(posedge iClock); #1;
      iReqValid = 1'b0; iReqWr = 1'b0; iReqAddr = '0; iReqData = '0; iReqMask = '0;
    end
  endtask

  task automatic wait_resp_valid();
    int n;
    n = 0;
    while (!oRespValid && n < 200) begin
      @(posedge iClock); #1; n++;
    end
    if (!oRespValid) chk("resp_wait_timeout", {63'h0, oRespValid}, 64'h1);
    resp_lat = cyc - acc_cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(posedge iClock); #1; n++;
    end
    if (busy) chk("drain_timeout", {63'h0, busy}, 64'h0);
    @(posedge iClock); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, {63'h0, oReqReady}, 64'h1);
    chk({tag, "_resp_valid"}, {63'h0, oRespValid}, 64'h0);
    chk({tag, "_resp_data"}, oRespData, 64'h0);
    chk({tag, "_resp_err"}, {63'h0, oRespErr}, 64'h0);
    chk({tag, "_valids"}, {59'h0, ar_valid, r_ready, aw_valid, w_valid, b_ready}, 64'h0);
    chk({tag, "_ar_addr"}, {32'h0, ar_addr}, 64'h0);
    chk({tag, "_w_data"}, w_data, 64'h0);
    chk({tag, "_w_strb"}, {56'h0, w_strb}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by t=500000");
    $fatal(1);
  end

  initial begin
    int cnt, n, base;
    repeat (3) @(posedge iClock);
    #1;
    chk_reset_state("por");
    iReset = 1'b1;
    chk_en = 1'b1;
    @(posedge iClock); #1;

    // Zero-wait read.
    cfg_rdata = 64'hDEAD_BEEF_0123_4567; cfg_resp = 2'b00;
    issue(1'b0, 32'h8000_0000, 64'h0, 8'h00);
    wait_resp_valid();
    chk("rd_latency", 64'(resp_lat), 64'd3);
    chk("rd_data_lit", oRespData, 64'hDEAD_BEEF_0123_4567);
    chk("rd_err_lit", {63'h0, oRespErr}, 64'h0);
    wait_idle();

    // Write: aw accepted two cycles before w.
    cfg_aw_lat = 0; cfg_w_lat = 2; cfg_b_lat = 0;
    issue(1'b1, 32'h8000_0010, 64'h11, 8'h0F);
    chk("wr_c1_valids", {62'h0, aw_valid, w_valid}, 64'h3);
    @(posedge iClock); #1;
    chk("wr_c2_valids", {61'h0, aw_valid, w_valid, b_ready}, 64'h2);
    @(posedge iClock); #1;
    chk("wr_c3_valids", {61'h0, aw_valid, w_valid, b_ready}, 64'h2);
    @(posedge iClock); #1;
    chk("wr_c4_valids", {61'h0, aw_valid, w_valid, b_ready}, 64'h1);
    wait_resp_valid();
    chk("wr_latency", 64'(resp_lat), 64'd5);
    chk("wr_data_lit", oRespData, 64'h0);
    chk("wr_err_lit", {63'h0, oRespErr}, 64'h0);
    wait_idle();
    cfg_w_lat = 0;

    // SLVERR read held by a stalled consumer.
    cfg_rdata = 64'h0123_4567_89AB_CDEF; cfg_resp = 2'b10;
    iRespReady = 1'b0;
    issue(1'b0, 32'h8000_0020, 64'h0, 8'h00);
    wait_resp_valid();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {63'h0, oRespValid}, 64'h1);
      chk("hold_data", oRespData, 64'h0123_4567_89AB_CDEF);
      chk("hold_err", {63'h0, oRespErr}, 64'h1);
      chk("hold_req_ready", {63'h0, oReqReady}, 64'h0);
      @(posedge iClock); #1;
    end
    iRespReady = 1'b1;
    wait_idle();
    cfg_resp = 2'b00;

    // Reset while waiting in the read-data phase.
    cfg_r_lat = 20;
    issue(1'b0, 32'h8000_0030, 64'hFFFF_0000_FFFF_0000, 8'hAA);
    n = 0;
    while (!r_ready && n < 50) begin
      @(posedge iClock); #1; n++;
    end
    chk("rst_reached_rdata", {63'h0, r_ready}, 64'h1);
    @(posedge iClock); #1;
    iReset = 1'b0;
    @(posedge iClock); #1;
    chk_reset_state("mid_rst");
    iReset = 1'b1;
    cfg_r_lat = 0;
    repeat (5) begin
      @(posedge iClock); #1;
      chk("post_rst_no_resp", {63'h0, oRespValid}, 64'h0);
    end

`ifdef AXI4_LITE_M_TIMEOUT_EN
    // Slave never takes the read address.
    cfg_ar_hang = 1'b1;
    issue(1'b0, 32'h8000_0040, 64'h0, 8'h00);
    cnt = 0; n = 0;
    while (!oRespValid && n < 100) begin
      if (ar_valid) cnt++;
      @(posedge iClock); #1; n++;
    end
    chk("to_ar_cycles", 64'(cnt), 64'd8);
    chk("to_ar_valid", {63'h0, ar_valid}, 64'h0);
    chk("to_resp_valid", {63'h0, oRespValid}, 64'h1);
    chk("to_err", {63'h0, oRespErr}, 64'h1);
    chk("to_data", oRespData, 64'h0);
    wait_idle();
    cfg_ar_hang = 1'b0;
`endif

    // Back-to-back read then write, consumer always ready.
    iRespReady = 1'b1;
    cfg_rdata = 64'hCAFE_F00D_0000_0001;
    base = resp_cnt;
    issue(1'b0, 32'h8000_0100, 64'h0, 8'h00);
    issue(1'b1, 32'h8000_0108, 64'hA5A5_5A5A_A5A5_5A5A, 8'hFF);
    chk("b2b_gap", 64'(acc_cyc - resp_hs_cyc), 64'd1);
    wait_idle();
    chk("b2b_resp_count", 64'(resp_cnt - base), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
